hazard_arbiter: RTL and testbench

Parametrised hazard controller for the mips_core pipeline. It turns per-stage stall and flush requests into per-register stall and flush controls, with stalls propagating upstream. It arbitrates multiple branch-redirect sources (older stage wins), honours delay slots, and holds a redirect in a pending register when IF cannot accept a new PC. It also keeps saturating per-register stall/flush counters and a stall watchdog.

---
 rtl/hazard_arbiter_if.sv | 39 +++
 rtl/hazard_arbiter.sv | 163 ++++++++++++++++
 tb/tb_hazard_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_arbiter_if.sv
// Bundle of pipeline hazard requests and controls exchanged between the
// mips_core pipeline (master) and the hazard arbiter (slave).
interface hazard_arbiter_if #(
    parameter int STAGES       = 5,
    parameter int NUM_REDIRECT = 2,
    parameter int PC_W         = 32,
    parameter int CNT_W        = 16,
    parameter int SIDX_W       = $clog2(STAGES)
);
    logic [STAGES-1:0]              stage_stall_req;
    logic [STAGES-1:0]              stage_flush_req;
    logic [NUM_REDIRECT-1:0]        redir_valid;
    logic [NUM_REDIRECT*SIDX_W-1:0] redir_src;
    logic [NUM_REDIRECT*PC_W-1:0]   redir_target;
    logic                           load_pc_ready;
    logic                           cnt_clear;
    logic [STAGES-1:0]              hc_stall;
    logic [STAGES-1:0]              hc_flush;
    logic                           load_pc_we;
    logic [PC_W-1:0]                load_pc_new_pc;
    logic                           redirect_pending;
    logic [STAGES*CNT_W-1:0]        stall_cnt;
    logic [STAGES*CNT_W-1:0]        flush_cnt;
    logic                           wdog_trip;

    modport master (
        output stage_stall_req, stage_flush_req, redir_valid, redir_src, redir_target,
               load_pc_ready, cnt_clear,
        input  hc_stall, hc_flush, load_pc_we, load_pc_new_pc, redirect_pending,
               stall_cnt, flush_cnt, wdog_trip
    );

    modport slave (
        input  stage_stall_req, stage_flush_req, redir_valid, redir_src, redir_target,
               load_pc_ready, cnt_clear,
        output hc_stall, hc_flush, load_pc_we, load_pc_new_pc, redirect_pending,
               stall_cnt, flush_cnt, wdog_trip
    );
endinterface

// File: rtl/hazard_arbiter.sv
// Pipeline hazard controller: stall/flush generation, oldest-first branch
// redirect arbitration with a pending-redirect holding register, event counters and a stall watchdog.
module hazard_arbiter #(
    parameter int STAGES       = 5,
    parameter int NUM_REDIRECT = 2,
    parameter int DELAY_SLOTS  = 1,
    parameter int PC_W         = 32,
    parameter int CNT_W        = 16,
    parameter int WDOG_LIMIT   = 1024,
    parameter int SIDX_W       = $clog2(STAGES)
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_arbiter_if.slave  bus
);
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WD_W-1:0]  WD_LIM  = WD_W'(WDOG_LIMIT);
    localparam logic [WD_W-1:0]  WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};

    logic                    acc_s;
    int                      win_idx_s;
    int                      src_idx_s;
    int                      kill_hi_s;
    logic                    blk_s;
    logic                    any_s;
    logic [PC_W-1:0]         win_tgt_s;
    logic [STAGES-1:0]       kill_s;
    logic [STAGES-1:0]       req_eff_s;
    logic [STAGES-1:0]       stall_s;
    logic [STAGES-1:0]       flush_s;
    logic                    issue_ok_s;
    logic                    cand_valid_s;
    logic [PC_W-1:0]         cand_pc_s;
    logic                    pc_we_s;
    logic [PC_W-1:0]         pc_new_s;

    logic                    pend_valid_r;
    logic [PC_W-1:0]         pend_pc_r;
    logic [STAGES*CNT_W-1:0] stall_cnt_r;
    logic [STAGES*CNT_W-1:0] flush_cnt_r;
    logic [WD_W-1:0]         wdog_cnt_r;
    logic                    wdog_trip_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
    endfunction

    // Redirect arbitration, kill range, stall propagation and PC load decision
    always_comb begin
        acc_s     = 1'b0;
        win_idx_s = 0;
        src_idx_s = 0;
        blk_s     = 1'b0;
        win_tgt_s = '0;
        for (int r = 0; r < NUM_REDIRECT; r++) begin
            src_idx_s = int'(bus.redir_src[r*SIDX_W +: SIDX_W]);
            blk_s     = 1'b0;
            for (int j = 0; j < STAGES; j++) begin
                blk_s = blk_s | (bus.stage_stall_req[j] && (j > src_idx_s));
            end
            // Strict compare keeps the lowest-numbered source on equal stage index
            if (bus.redir_valid[r] && !blk_s && (!acc_s || (src_idx_s > win_idx_s))) begin
                acc_s     = 1'b1;
                win_idx_s = src_idx_s;
                win_tgt_s = bus.redir_target[r*PC_W +: PC_W];
            end else begin
                acc_s     = acc_s;
            end
        end

        kill_hi_s = win_idx_s - DELAY_SLOTS;
        for (int j = 0; j < STAGES; j++) begin
            kill_s[j]    = acc_s && (j <= kill_hi_s);
            req_eff_s[j] = bus.stage_stall_req[j] & ~kill_s[j];
            flush_s[j]   = (j >= 1) && (kill_s[j] || bus.stage_flush_req[j]);
        end

        any_s = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            any_s      = any_s | req_eff_s[i];
            stall_s[i] = any_s;
        end

        issue_ok_s   = bus.load_pc_ready && (req_eff_s[STAGES-1:1] == '0);
        cand_valid_s = acc_s || pend_valid_r;
        cand_pc_s    = acc_s ? win_tgt_s : pend_pc_r;
        pc_we_s      = 1'b0;
        pc_new_s     = '0;
        if (cand_valid_s) begin
            if (issue_ok_s) begin
                pc_we_s    = 1'b1;
                pc_new_s   = cand_pc_s;
                stall_s[0] = 1'b0;
            end else begin
                // Hold the PC and bubble IF/ID so no wrong-path fetch slips in
                stall_s[0] = 1'b1;
                flush_s[1] = 1'b1;
            end
        end else begin
            pc_we_s  = 1'b0;
            pc_new_s = '0;
        end
    end

    // Pending redirect register; a fresh acceptance always replaces the held one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_r <= 1'b0;
            pend_pc_r    <= '0;
        end else if (cand_valid_s && !issue_ok_s) begin
            pend_valid_r <= 1'b1;
            pend_pc_r    <= cand_pc_s;
        end else if (cand_valid_s) begin
            pend_valid_r <= 1'b0;
            pend_pc_r    <= '0;
        end else begin
            pend_valid_r <= pend_valid_r;
            pend_pc_r    <= pend_pc_r;
        end
    end

    // Saturating per-register stall and effective-flush counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else if (bus.cnt_clear) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stall_cnt_r[i*CNT_W +: CNT_W] <= sat_inc(stall_cnt_r[i*CNT_W +: CNT_W], stall_s[i]);
                flush_cnt_r[i*CNT_W +: CNT_W] <= sat_inc(flush_cnt_r[i*CNT_W +: CNT_W],
                                                         flush_s[i] & ~stall_s[i]);
            end
        end
    end

    // Stall watchdog: consecutive cycles with any effective stall request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_r  <= '0;
            wdog_trip_r <= 1'b0;
        end else if (|req_eff_s) begin
            wdog_cnt_r  <= (wdog_cnt_r == WD_LIM) ? wdog_cnt_r : wdog_cnt_r + WD_ONE;
            wdog_trip_r <= wdog_trip_r | (wdog_cnt_r >= (WD_LIM - WD_ONE));
        end else begin
            wdog_cnt_r  <= '0;
            wdog_trip_r <= wdog_trip_r;
        end
    end

    assign bus.hc_stall         = stall_s;
    assign bus.hc_flush         = flush_s;
    assign bus.load_pc_we       = pc_we_s;
    assign bus.load_pc_new_pc   = pc_new_s;
    assign bus.redirect_pending = pend_valid_r;
    assign bus.stall_cnt        = stall_cnt_r;
    assign bus.flush_cnt        = flush_cnt_r;
    assign bus.wdog_trip        = wdog_trip_r;
endmodule

// File: tb/tb_hazard_arbiter.sv
// Directed bench for hazard_arbiter: expected controls queued at drive time, popped at the sample point.
module tb_hazard_arbiter;
    localparam int ST = 5;
    localparam int NR = 2;
    localparam int PW = 32;
    localparam int CW = 4;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hazard_arbiter_if #(.STAGES(ST), .NUM_REDIRECT(NR), .PC_W(PW), .CNT_W(CW), .SIDX_W(SW)) bus();

    hazard_arbiter #(
        .STAGES(ST), .NUM_REDIRECT(NR), .DELAY_SLOTS(1), .PC_W(PW),
        .CNT_W(CW), .WDOG_LIMIT(8), .SIDX_W(SW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [ST-1:0] stall;
        logic [ST-1:0] flush;
        logic          we;
        logic [PW-1:0] pc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input logic [ST-1:0] s, input logic [ST-1:0] f,
                              input logic w, input logic [PW-1:0] p);
        exp_t e;
        e.stall = s;
        e.flush = f;
        e.we    = w;
        e.pc    = p;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".stall"}, 64'(bus.hc_stall), 64'(e.stall));
            chk({tag, ".flush"}, 64'(bus.hc_flush), 64'(e.flush));
            chk({tag, ".we"},    64'(bus.load_pc_we), 64'(e.we));
            chk({tag, ".pc"},    64'(bus.load_pc_new_pc), 64'(e.pc));
        end
    endtask

    task automatic idle();
        bus.stage_stall_req = '0;
        bus.stage_flush_req = '0;
        bus.redir_valid     = '0;
        bus.redir_src       = '0;
        bus.redir_target    = '0;
        bus.load_pc_ready   = 1'b1;
        bus.cnt_clear       = 1'b0;
    endtask

    task automatic set_redir(input int r, input int src, input logic [PW-1:0] tgt);
        bus.redir_valid[r]            = 1'b1;
        bus.redir_src[r*SW +: SW]     = SW'(src);
        bus.redir_target[r*PW +: PW]  = tgt;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        chk("rst.pending",   64'(bus.redirect_pending), 64'd0);
        chk("rst.wdog",      64'(bus.wdog_trip), 64'd0);
        chk("rst.stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("rst.flush_cnt", 64'(bus.flush_cnt), 64'd0);
        sample();
        rst_n = 1'b1;

        // Base stall propagation and flush request
        next_cycle(); idle();
        bus.stage_stall_req = 5'b01000;
        bus.stage_flush_req = 5'b10000;
        expect_out(5'b01111, 5'b10000, 1'b0, 32'h0);
        sample(); check_out("base");

        next_cycle(); idle();
        expect_out(5'b00000, 5'b00000, 1'b0, 32'h0);
        sample(); check_out("idle");
        chk("cnt.stall_after_base", 64'(bus.stall_cnt), 64'h01111);
        chk("cnt.flush_after_base", 64'(bus.flush_cnt), 64'h10000);

        // Simple redirect, then with I$ miss that must not block it
        next_cycle(); idle();
        set_redir(0, 2, 32'h400);
        expect_out(5'b00000, 5'b00010, 1'b1, 32'h400);
        sample(); check_out("redir");

        next_cycle(); idle();
        set_redir(0, 2, 32'h400);
        bus.stage_stall_req = 5'b00001;
        expect_out(5'b00000, 5'b00010, 1'b1, 32'h400);
        sample(); check_out("redir_imiss");

        // Redirect blocked by IF for three cycles
        next_cycle(); idle();
        set_redir(0, 2, 32'h400);
        bus.load_pc_ready = 1'b0;
        expect_out(5'b00001, 5'b00010, 1'b0, 32'h0);
        sample(); check_out("blk1");
        for (int k = 2; k <= 3; k++) begin
            next_cycle(); idle();
            bus.load_pc_ready = 1'b0;
            expect_out(5'b00001, 5'b00010, 1'b0, 32'h0);
            sample(); check_out("blk_hold");
            chk("blk_hold.pending", 64'(bus.redirect_pending), 64'd1);
        end
        next_cycle(); idle();
        expect_out(5'b00000, 5'b00000, 1'b1, 32'h400);
        sample(); check_out("blk_issue");
        chk("blk_issue.pending", 64'(bus.redirect_pending), 64'd1);
        next_cycle(); idle();
        expect_out(5'b00000, 5'b00000, 1'b0, 32'h0);
        sample(); check_out("blk_done");
        chk("blk_done.pending", 64'(bus.redirect_pending), 64'd0);

        // Arbitration: older stage wins, tie goes to lower source
        next_cycle(); idle();
        set_redir(0, 1, 32'h100);
        set_redir(1, 2, 32'h200);
        expect_out(5'b00000, 5'b00010, 1'b1, 32'h200);
        sample(); check_out("arb_older");

        next_cycle(); idle();
        set_redir(0, 2, 32'h111);
        set_redir(1, 2, 32'h222);
        expect_out(5'b00000, 5'b00010, 1'b1, 32'h111);
        sample(); check_out("arb_tie");

        // Pending redirect overwritten by a newly accepted older source
        next_cycle(); idle();
        set_redir(0, 1, 32'h100);
        bus.load_pc_ready = 1'b0;
        expect_out(5'b00001, 5'b00010, 1'b0, 32'h0);
        sample(); check_out("pend_100");
        next_cycle(); idle();
        set_redir(0, 3, 32'h300);
        bus.load_pc_ready = 1'b0;
        expect_out(5'b00001, 5'b00110, 1'b0, 32'h0);
        sample(); check_out("pend_300");
        next_cycle(); idle();
        expect_out(5'b00000, 5'b00000, 1'b1, 32'h300);
        sample(); check_out("pend_issue");

        // Eligibility: src1 blocked by a younger-stage D$ stall, src3 accepted but cannot issue
        next_cycle(); idle();
        set_redir(0, 1, 32'h100);
        set_redir(1, 3, 32'h333);
        bus.stage_stall_req = 5'b01000;
        expect_out(5'b01111, 5'b00110, 1'b0, 32'h0);
        sample(); check_out("elig");
        next_cycle(); idle();
        expect_out(5'b00000, 5'b00000, 1'b1, 32'h333);
        sample(); check_out("elig_issue");

        // Reset in the middle of a held redirect
        next_cycle(); idle();
        set_redir(0, 2, 32'h500);
        bus.load_pc_ready = 1'b0;
        expect_out(5'b00001, 5'b00010, 1'b0, 32'h0);
        sample(); check_out("rstmid_blk");
        next_cycle(); idle();
        bus.load_pc_ready = 1'b0;
        expect_out(5'b00001, 5'b00010, 1'b0, 32'h0);
        sample(); check_out("rstmid_hold");
        chk("rstmid.pending_before", 64'(bus.redirect_pending), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid.pending_async", 64'(bus.redirect_pending), 64'd0);
        sample();
        rst_n = 1'b1;
        next_cycle(); idle();
        expect_out(5'b00000, 5'b00000, 1'b0, 32'h0);
        sample(); check_out("rstmid_discard");

        // Long I$ miss: counter saturation and watchdog
        for (int k = 1; k <= 20; k++) begin
            next_cycle(); idle();
            bus.stage_stall_req = 5'b00001;
            expect_out(5'b00001, 5'b00000, 1'b0, 32'h0);
            sample(); check_out("wd_stall");
            if (k == 8) chk("wdog.before_limit", 64'(bus.wdog_trip), 64'd0);
            if (k == 9) chk("wdog.at_limit", 64'(bus.wdog_trip), 64'd1);
        end
        next_cycle(); idle();
        sample();
        chk("cnt.stall_sat", 64'(bus.stall_cnt), 64'h0000F);
        chk("cnt.flush_zero", 64'(bus.flush_cnt), 64'h0);
        chk("wdog.sticky", 64'(bus.wdog_trip), 64'd1);

        // Clear beats a simultaneous increment; watchdog flag survives
        next_cycle(); idle();
        bus.cnt_clear = 1'b1;
        bus.stage_stall_req = 5'b00001;
        sample();
        next_cycle(); idle();
        sample();
        chk("clr.stall_cnt", 64'(bus.stall_cnt), 64'h0);
        chk("clr.flush_cnt", 64'(bus.flush_cnt), 64'h0);
        chk("clr.wdog_kept", 64'(bus.wdog_trip), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("wdog.reset", 64'(bus.wdog_trip), 64'd0);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
